// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin or fixed-priority grant, registered operands, buffered response.
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_instr,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_instr,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] alu_instruction,
  output logic [31:0] alu_regA,
  output logic [31:0] alu_regB,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [2:0]  rsp_flags,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        rsp_id_q, rsp_id_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;
  logic [2:0]  flags_q, flags_d;
  logic [15:0] op_count_q, op_count_d;

  logic grant_vld;
  logic grant;
  logic idle;
  logic accept;

  // On contention the port that did not win last time goes next
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant     = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = FIXED_PRIO ? 1'b0 : ~last_grant_q;
    end else begin
      grant = req1_valid;
    end
  end

  assign idle       = (state_q == IDLE) && !rst;
  assign req0_ready = idle && grant_vld && !grant;
  assign req1_ready = idle && grant_vld && grant;
  assign accept     = (req0_valid && req0_ready) ||
                      (req1_valid && req1_ready);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_valid_d  = rsp_valid_q;
    instr_d      = instr_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    flags_d      = flags_q;
    op_count_d   = op_count_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          instr_d      = grant ? req1_instr : req0_instr;
          a_d          = grant ? req1_a : req0_a;
          b_d          = grant ? req1_b : req0_b;
          rsp_id_d     = grant;
          last_grant_d = grant;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d    = alu_result;
        flags_d     = alu_flags;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      instr_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      flags_q      <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_valid_q  <= rsp_valid_d;
      instr_q      <= instr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      op_count_q   <= op_count_d;
    end
  end

  assign alu_instruction = instr_q;
  assign alu_regA        = a_q;
  assign alu_regB        = b_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = rsp_id_q;
  assign rsp_result      = result_q;
  assign rsp_flags       = flags_q;
  assign busy            = (state_q != IDLE);
  assign op_count        = op_count_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between two requesters (port 0: EX-stage issue, port 1: branch-resolution / auxiliary unit) in the MIPS pipeline. It accepts one operation at a time over a valid/ready handshake, drives the ALU from registered operands, captures `result`/`flags` and returns them on a single response channel with backpressure. Grants are round-robin by default, with a fixed-priority option.

## Interface
- `FIXED_PRIO`, default 0: 0 = round-robin between ports; 1 = port 0 always wins.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  port 0 has an operation.
- `req0_ready`  out  1  port 0 operation accepted this cycle when high with `req0_valid`.
- `req0_instr`  in  32  port 0 instruction word.
- `req0_a`, `req0_b`  in  32 each  port 0 regA/regB operands.
- `req1_valid`, `req1_ready`, `req1_instr`, `req1_a`, `req1_b`: same as port 0, for port 1.
- `alu_instruction`  out  32  to ALU `instruction`.
- `alu_regA`, `alu_regB`  out  32 each  to ALU `regA`/`regB`.
- `alu_result`  in  32  from ALU `result`.
- `alu_flags`  in  3  from ALU `flags`: [2] zero, [1] negative, [0] overflow.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_id`  out  1  port that issued the operation.
- `rsp_result`  out  32  captured ALU result.
- `rsp_flags`  out  3  captured ALU flags.
- `busy`  out  1  high whenever state is not IDLE.
- `op_count`  out  16  completed responses, modulo 2^16.

## Operation
- States: IDLE, EXEC, RESP.
- **IDLE**
  - Grant selection is combinational from `req0_valid`, `req1_valid`, `last_grant` and `FIXED_PRIO`.
  - Only one valid: that port is granted.
  - Both valid with `FIXED_PRIO`=1: port 0 granted.
  - Both valid with `FIXED_PRIO`=0: the port other than `last_grant` is granted.
  - `reqN_ready` = (state==IDLE) && grant==N. The non-granted port's ready stays 0.
  - On a handshake:
    - latch instr/a/b into the operand registers;
    - set `rsp_id` to the granted port and `last_grant` to the granted port;
    - go to EXEC.
- **EXEC**: lasts exactly one cycle.
  - ALU inputs come from the operand registers and are stable.
  - At the clock edge, capture `alu_result` into `rsp_result` and `alu_flags` into `rsp_flags`, set `rsp_valid`=1, go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_result`, `rsp_flags` and `rsp_id` are held stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`: clear `rsp_valid`, increment `op_count` (0xFFFF wraps to 0x0000), go to IDLE.
  - No request is accepted in RESP, even in the handshake cycle.
- Operand registers hold their last value after completion. `alu_*` outputs are always driven from the operand registers.
- Request inputs are sampled only at the handshake. Changes while not ready are ignored.
- The block does not interpret the instruction or flags; any encoding passes through unchanged.

## Timing
- Reset values (asynchronous assertion):
  - state IDLE; `last_grant`=1, so port 0 wins the first contention;
  - `alu_instruction`, `alu_regA`, `alu_regB` = 0;
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_flags`=0;
  - `op_count`=0, `busy`=0;
  - `req0_ready` and `req1_ready` are 0 while `rst` is high.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded and no response is produced.
- Latency: handshake at edge N; `rsp_valid` rises after edge N+1, one cycle in EXEC.
- Minimum issue interval is 3 cycles (IDLE, EXEC, RESP with `rsp_ready` held high).
- Round-robin with both ports continuously valid: strict alternation 0,1,0,1…
- Starvation bound in round-robin: one competing operation.

## Test plan
- Port 0 only, `req0_instr`=0x00000020 (add), a=5, b=7, `rsp_ready`=1:
  - `req0_ready` is high in the accept cycle;
  - `rsp_valid` rises 2 edges after accept with `rsp_result`=12, `rsp_flags`=000, `rsp_id`=0;
  - `op_count`=1 afterwards.
- Port 1 add with a=0x7FFFFFFF, b=1: `rsp_result`=0x80000000, `rsp_flags`[0]=1, `rsp_id`=1.
- Both ports continuously valid, `FIXED_PRIO`=0, for 4 operations:
  - `rsp_id` sequence 0,1,0,1;
  - `req1_ready` stays low whenever port 0 is granted, and vice versa.
- Same stimulus with `FIXED_PRIO`=1: `rsp_id` sequence 0,0,0,0; port 1 is never ready while `req0_valid` is high.
- `rsp_ready` held low 5 cycles in RESP:
  - `rsp_valid`, `rsp_result` and `rsp_id` stay stable;
  - both `reqN_ready` stay 0 and `busy`=1;
  - on release, exactly one response completes and `op_count` increments by 1.
- Assert `rst` in EXEC:
  - all outputs return to their reset values immediately;
  - no response appears after deassertion;
  - the next port 0 request completes normally with `op_count`=1.
